// File: rtl/contador_mod_param_if.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod_param_if
// Brief    : Control/status bundle of the modulo-N up/down counter.
// Revision : 1.0
// ============================================================================
interface contador_mod_param_if #(
    parameter int WIDTH = 16
);
    logic             zera;
    logic             carrega;
    logic             ent;
    logic             enp;
    logic             up_down;
    logic             one_shot;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             rco;
    logic             meio;
    logic             fim;
    logic             parado;

    modport master (
        output zera, carrega, ent, enp, up_down, one_shot, D,
        input  Q, rco, meio, fim, parado
    );

    modport slave (
        input  zera, carrega, ent, enp, up_down, one_shot, D,
        output Q, rco, meio, fim, parado
    );
endinterface
`default_nettype wire

// File: rtl/contador_mod_param.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod_param
// Brief    : Modulo-N up/down counter with clamped load, one-shot stop,
//            half-range flag, cascade carry and registered wrap pulse.
// Revision : 1.0
// ============================================================================
module contador_mod_param #(
    parameter int WIDTH  = 16,
    parameter int MODULO = 50000
) (
    input  wire logic               clock,
    input  wire logic               reset,
    contador_mod_param_if.slave     bus
);
    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] c_half = WIDTH'(MODULO / 2);

    logic [WIDTH-1:0] r_q;
    logic             r_fim;
    logic             r_parado;

    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_load_val;
    logic             w_at_term;
    logic             w_step;

    // Terminal value follows the current direction, so rco reacts to up_down at once
    assign w_term     = bus.up_down ? c_max : '0;
    assign w_at_term  = (r_q == w_term);
    assign w_step     = bus.ent && bus.enp && !r_parado;
    assign w_load_val = (bus.D > c_max) ? c_max : bus.D;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            r_fim    <= 1'b0;
            r_parado <= 1'b0;
        end else if (bus.zera) begin
            r_q      <= '0;
            r_fim    <= 1'b0;
            r_parado <= 1'b0;
        end else if (bus.carrega) begin
            r_q      <= w_load_val;
            r_fim    <= 1'b0;
            r_parado <= 1'b0;
        end else if (w_step) begin
            if (w_at_term) begin
                r_fim <= 1'b1;
                if (bus.one_shot) begin
                    r_parado <= 1'b1;
                end else begin
                    r_q <= bus.up_down ? '0 : c_max;
                end
            end else begin
                r_fim <= 1'b0;
                // Away from the terminal neither direction can leave 0..MODULO-1
                r_q   <= bus.up_down ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
            end
        end else begin
            r_fim <= 1'b0;
        end
    end

    assign bus.Q      = r_q;
    assign bus.fim    = r_fim;
    assign bus.parado = r_parado;
    assign bus.rco    = bus.ent && w_at_term;
    assign bus.meio   = (r_q >= c_half);

endmodule
`default_nettype wire
